// File: rtl/pacman_kb_pkg.sv
// Shared types and PS/2 scan codes for the keyboard direction decoder.
package pacman_kb_pkg;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_t;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;

    localparam logic [7:0] ARR_UP    = 8'h75;
    localparam logic [7:0] ARR_DOWN  = 8'h72;
    localparam logic [7:0] ARR_LEFT  = 8'h6B;
    localparam logic [7:0] ARR_RIGHT = 8'h74;

    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_D     = 8'h23;

    // Bit position in the {up,down,left,right} mask for a direction.
    function automatic logic [3:0] dir_mask(dir_t d);
        case (d)
            DIR_UP:    return 4'b1000;
            DIR_DOWN:  return 4'b0100;
            DIR_LEFT:  return 4'b0010;
            DIR_RIGHT: return 4'b0001;
            default:   return 4'b0000;
        endcase
    endfunction

    // Fixed fallback priority when the active key is released: up > down > left > right.
    function automatic dir_t pick_dir(logic [3:0] mask);
        if (mask[3]) return DIR_UP;
        if (mask[2]) return DIR_DOWN;
        if (mask[1]) return DIR_LEFT;
        if (mask[0]) return DIR_RIGHT;
        return DIR_NONE;
    endfunction

endpackage

// File: rtl/ps2_dir_arbiter.sv
// Tracks held direction keys and the last-pressed one; drives the registered one-hot
// direction and a pulse whenever that direction changes.
module ps2_dir_arbiter
    import pacman_kb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       make_i,
    input  logic       brk_i,
    input  dir_t       key_i,
    output logic [3:0] held_o,
    output logic [3:0] onehot_o,
    output logic       dir_change_o
);

    logic [3:0] held_q, held_d;
    dir_t       last_q, last_d;
    logic [3:0] onehot_q, onehot_d;
    logic       dir_change_q, dir_change_d;
    logic [3:0] key_mask;

    assign key_mask = dir_mask(key_i);

    always_comb begin
        held_d = held_q;
        last_d = last_q;
        if (make_i) begin
            held_d = held_q | key_mask;
            last_d = key_i;
        end else if (brk_i && ((held_q & key_mask) != 4'b0000)) begin
            held_d = held_q & ~key_mask;
            if (last_q == key_i) begin
                last_d = pick_dir(held_d);
            end
        end
        onehot_d     = dir_mask(last_d);
        dir_change_d = (onehot_d != onehot_q);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q       <= 4'b0000;
            last_q       <= DIR_NONE;
            onehot_q     <= 4'b0000;
            dir_change_q <= 1'b0;
        end else begin
            held_q       <= held_d;
            last_q       <= last_d;
            onehot_q     <= onehot_d;
            dir_change_q <= dir_change_d;
        end
    end

    assign held_o       = held_q;
    assign onehot_o     = onehot_q;
    assign dir_change_o = dir_change_q;

endmodule

// File: rtl/ps2_dir_decoder.sv
// PS/2 byte stream to held-direction controls: prefix FSM with timeout, code map,
// and the direction arbiter.
module ps2_dir_decoder
    import pacman_kb_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 50000,
    parameter int ENABLE_WASD    = 1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic [3:0] held,
    output logic       dir_change
);

    localparam int CNT_W = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PREFIX_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             make_ev, brk_ev;
    dir_t             key;
    logic [3:0]       onehot;

    // An arrow code only counts after E0; WASD codes only without it.
    function automatic dir_t map_code(logic [7:0] b, logic ext);
        if (ext) begin
            case (b)
                ARR_UP:    return DIR_UP;
                ARR_DOWN:  return DIR_DOWN;
                ARR_LEFT:  return DIR_LEFT;
                ARR_RIGHT: return DIR_RIGHT;
                default:   return DIR_NONE;
            endcase
        end else if (ENABLE_WASD != 0) begin
            case (b)
                KEY_W:   return DIR_UP;
                KEY_S:   return DIR_DOWN;
                KEY_A:   return DIR_LEFT;
                KEY_D:   return DIR_RIGHT;
                default: return DIR_NONE;
            endcase
        end
        return DIR_NONE;
    endfunction

    // NOTE: every combinational output gets a default first, so no path through the
    // case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        make_ev = 1'b0;
        brk_ev  = 1'b0;
        key     = DIR_NONE;
        if (byte_valid) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            case (state_q)
                ST_IDLE: begin
                    if (byte_data == PFX_EXT)      state_d = ST_EXT;
                    else if (byte_data == PFX_BRK) state_d = ST_BRK;
                    else begin
                        key     = map_code(byte_data, 1'b0);
                        make_ev = (key != DIR_NONE);
                    end
                end
                ST_EXT: begin
                    if (byte_data == PFX_BRK) state_d = ST_EXT_BRK;
                    else begin
                        key     = map_code(byte_data, 1'b1);
                        make_ev = (key != DIR_NONE);
                    end
                end
                ST_BRK: begin
                    if (byte_data == PFX_EXT) state_d = ST_EXT_BRK;
                    else begin
                        key    = map_code(byte_data, 1'b0);
                        brk_ev = (key != DIR_NONE);
                    end
                end
                default: begin
                    key    = map_code(byte_data, 1'b1);
                    brk_ev = (key != DIR_NONE);
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            // A byte arriving in the expiry cycle takes the branch above instead.
            if (cnt_q == CNT_MAX) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    ps2_dir_arbiter u_arbiter (
        .clk          (CLOCK_50),
        .rst_n        (reset),
        .make_i       (make_ev),
        .brk_i        (brk_ev),
        .key_i        (key),
        .held_o       (held),
        .onehot_o     (onehot),
        .dir_change_o (dir_change)
    );

    assign {up, down, left, right} = onehot;

endmodule

// File: doc/ps2_dir_decoder.md
Name: ps2_dir_decoder

Overview:
- Converts the raw PS/2 byte stream from the keyboard receiver into the held-direction controls up/down/left/right.
- Sits between the PS/2 byte receiver and pacman_loc_ctrl, and replaces the KEY[3:0] direction inputs.
- Handles E0 (extended) and F0 (break) prefixes, tracks which direction keys are held, and drives a registered one-hot direction.
- Policy: the most recently pressed key that is still held wins.

Parameters:
- PREFIX_TIMEOUT, 50000: CLOCK_50 cycles allowed between a prefix byte and its code byte before the decoder resynchronises to IDLE.
- ENABLE_WASD, 1: when 1, W/S/A/D keys map to directions in addition to the arrow keys.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low reset.
- byte_valid  input  1  one-cycle strobe; byte_data is valid this cycle.
- byte_data  input  8  received PS/2 byte.
- up  output  1  direction up is active.
- down  output  1  direction down is active.
- left  output  1  direction left is active.
- right  output  1  direction right is active.
- held  output  4  held-key mask {up,down,left,right}.
- dir_change  output  1  one-cycle pulse when the one-hot direction output changes.

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE, held=0, last direction=NONE, up/down/left/right=0, dir_change=0, timeout counter=0.
- FSM states, advancing only on byte_valid:
  - IDLE: E0->EXT; F0->BRK; mapped code->make event; any other byte->IDLE (covers FA, AA, E1 and unmapped codes).
  - EXT: F0->EXT_BRK; mapped extended code->make event, then IDLE; any other byte->IDLE.
  - BRK: E0->EXT_BRK (tolerated ordering); mapped code->break event, then IDLE; any other byte->IDLE.
  - EXT_BRK: mapped extended code->break event, then IDLE; any other byte->IDLE.
- Code map:
  - Extended: 75=up, 72=down, 6B=left, 74=right.
  - Non-extended, only when ENABLE_WASD=1: 1D=up, 1B=down, 1C=left, 23=right.
  - An extended code seen without the E0 prefix is unmapped.
- Timeout:
  - The counter runs only in EXT, BRK and EXT_BRK, and clears on every byte_valid.
  - When the counter reaches PREFIX_TIMEOUT-1 with no byte, the FSM goes to IDLE and the counter clears.
  - If byte_valid arrives in the same cycle as expiry, the byte wins and is decoded in the current state.
- Make event for key k:
  - held[k]<=1 and last<=k.
  - Typematic repeats of an already-held k re-assert last<=k.
- Break event for key k:
  - held[k]<=0.
  - If last==k, last<=highest-priority remaining held key (up>down>left>right, evaluated on the mask with k cleared), or NONE if no key is held.
  - Break of a key that is not held: no change.
- Outputs:
  - up/down/left/right are registered one-hot decodes of last; all are 0 when last is NONE.
  - Latency: the outputs change on the clock edge after the cycle in which the final byte's byte_valid is high.
  - dir_change pulses for exactly one cycle, aligned with the cycle in which the new output value first appears.
- Width rules: timeout counter width is $clog2(PREFIX_TIMEOUT); held and last update in the same cycle.
- byte_valid held high for multiple cycles is treated as multiple bytes. The upstream receiver guarantees single-cycle strobes.

Decomposition:
- Package pacman_kb_pkg holds:
  - typedef enum dir_t {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}.
  - typedef enum for FSM states.
  - localparams for scan codes: PFX_EXT=E0, PFX_BRK=F0, arrow codes, WASD codes.
- Sub-module ps2_dir_arbiter: takes make/break events plus key index, and owns held, last, the one-hot output register and dir_change.
- ps2_dir_decoder keeps the prefix FSM, the timeout counter and the code map.

Test Plan:
- Reset, then E0 75 with byte_valid at cycles 10 and 20 -> up=1 at cycle 21, held=4'b1000, dir_change pulse at cycle 21; all outputs 0 before that.
- Press up (E0 75), press left (E0 6B), then release left (E0 F0 6B) -> left=1 after the second make; after the break, up=1 with a single dir_change pulse; held ends at 4'b1000.
- Press left and right, release right, release left -> sequence right, left, none; held=0; release of a non-held key (E0 F0 72) produces no output change and no pulse.
- Send E0 only, wait PREFIX_TIMEOUT cycles, then send 1D with ENABLE_WASD=1 -> FSM back in IDLE, 1D decodes as W make, up=1; the same sequence with ENABLE_WASD=0 gives no change.
- Send E0, then 75 in the exact expiry cycle -> byte wins and up=1; bytes FA, AA and E1 14 77 in IDLE -> no output change.
- Assert reset low mid-sequence (after E0 F0) while up is held -> all outputs 0 immediately; after release, 75 alone is unmapped and gives no change.
